// File: rtl/cache_pkg.sv
// Shared types, widths and the round-robin selection helper for the cache read arbiter.
package cache_pkg;

    localparam int LEN_W       = 16;
    localparam int CNT_W       = LEN_W + 1;
    localparam int MAX_CLIENTS = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        DONE
    } state_t;

    // Returns {found, index}: the first requester after 'last' (one-hot), wrapping over n clients.
    function automatic logic [3:0] rr_pick(input logic [MAX_CLIENTS-1:0] req,
                                           input logic [MAX_CLIENTS-1:0] last,
                                           input int unsigned            n);
        logic       found;
        logic [2:0] last_idx;
        logic [2:0] idx;
        logic [2:0] win;
        found    = 1'b0;
        last_idx = '0;
        idx      = '0;
        win      = '0;
        for (int unsigned i = 0; i < MAX_CLIENTS; i++) begin
            if (last[i]) last_idx = 3'(i);
        end
        for (int unsigned k = 1; k <= MAX_CLIENTS; k++) begin
            if (k <= n && !found) begin
                idx = 3'((32'(last_idx) + k) % n);
                if (req[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        return {found, win};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Pointer-based round-robin arbiter: one-hot grant to the first requester after the last winner.
module rr_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_CLIENTS = 2
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [NUM_CLIENTS-1:0] last_i,
    output logic [NUM_CLIENTS-1:0] gnt_o,
    output logic                   any_o
);

    logic [3:0] pick;

    // Pick the winner and decode it to a one-hot grant.
    always_comb begin
        pick  = rr_pick(MAX_CLIENTS'(req_i), MAX_CLIENTS'(last_i), NUM_CLIENTS);
        gnt_o = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            gnt_o[i] = pick[3] && (pick[2:0] == 3'(i));
        end
        any_o = pick[3];
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Arbitrates burst reads from several cache controllers onto one memory read port.
// One burst is in flight at a time; data is passed through to the owning client.
module cache_rd_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_CLIENTS = 2,
    parameter int addr_width  = 32,
    parameter int data_width  = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLIENTS-1:0]            c_rd_req,
    output logic [NUM_CLIENTS-1:0]            c_rd_gnt,
    input  logic [NUM_CLIENTS*LEN_W-1:0]      c_rd_len,
    input  logic [NUM_CLIENTS*addr_width-1:0] c_rd_addr,
    output logic [data_width-1:0]             c_rd_data,
    output logic [NUM_CLIENTS-1:0]            c_rd_valid,
    input  logic [NUM_CLIENTS-1:0]            c_rd_ready,
    output logic [NUM_CLIENTS-1:0]            c_rd_done,
    output logic                              rd_req,
    input  logic                              rd_gnt,
    output logic [LEN_W-1:0]                  rd_len,
    output logic [addr_width-1:0]             rd_addr,
    input  logic [data_width-1:0]             rd_data,
    input  logic                              rd_valid,
    output logic                              rd_ready,
    input  logic                              rd_done,
    output logic                              len_err
);

    localparam logic [NUM_CLIENTS-1:0] PTR_RST = NUM_CLIENTS'(1) << (NUM_CLIENTS - 1);

    state_t                  state_q, state_d;
    logic [NUM_CLIENTS-1:0]  ptr_q;
    logic [NUM_CLIENTS-1:0]  own_q;
    logic [NUM_CLIENTS-1:0]  gnt_q, gnt_d;
    logic [LEN_W-1:0]        len_q;
    logic [addr_width-1:0]   addr_q;
    logic [CNT_W-1:0]        cnt_q;

    logic [NUM_CLIENTS-1:0]  arb_gnt;
    logic                    arb_any;
    logic [LEN_W-1:0]        sel_len;
    logic [addr_width-1:0]   sel_addr;
    logic                    grant_en;
    logic                    cnt_clr;
    logic                    beat;

    rr_arbiter #(
        .NUM_CLIENTS(NUM_CLIENTS)
    ) u_rr (
        .req_i (c_rd_req),
        .last_i(ptr_q),
        .gnt_o (arb_gnt),
        .any_o (arb_any)
    );

    // Route the winning client's burst descriptor toward the memory-side registers.
    always_comb begin
        sel_len  = '0;
        sel_addr = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (arb_gnt[i]) begin
                sel_len  = c_rd_len[i*LEN_W +: LEN_W];
                sel_addr = c_rd_addr[i*addr_width +: addr_width];
            end
        end
    end

    // Next-state and per-state outputs; data and handshakes only reach the owner during XFER.
    always_comb begin
        state_d    = state_q;
        grant_en   = 1'b0;
        cnt_clr    = 1'b0;
        rd_req     = 1'b0;
        rd_ready   = 1'b0;
        c_rd_valid = '0;
        c_rd_done  = '0;
        c_rd_data  = '0;
        len_err    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_en = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                rd_req = 1'b1;
                if (rd_gnt) begin
                    cnt_clr = 1'b1;
                    state_d = XFER;
                end
            end
            XFER: begin
                rd_ready   = |(c_rd_ready & own_q);
                c_rd_valid = own_q & {NUM_CLIENTS{rd_valid}};
                c_rd_data  = rd_data;
                if (rd_done) state_d = DONE;
            end
            DONE: begin
                c_rd_done = own_q;
                len_err   = (cnt_q != ({1'b0, len_q} + CNT_W'(1)));
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        gnt_d = grant_en ? arb_gnt : '0;
        beat  = rd_valid && rd_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Grant pulse, round-robin pointer, owner, latched descriptor and saturating beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q  <= '0;
            ptr_q  <= PTR_RST;
            own_q  <= '0;
            len_q  <= '0;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            gnt_q <= gnt_d;
            if (grant_en) begin
                ptr_q  <= arb_gnt;
                own_q  <= arb_gnt;
                len_q  <= sel_len;
                addr_q <= sel_addr;
            end
            if (cnt_clr)                 cnt_q <= '0;
            else if (beat && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign c_rd_gnt = gnt_q;
    assign rd_len   = len_q;
    assign rd_addr  = addr_q;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomized and directed bench for cache_rd_arbiter against a transaction-level model.
module tb_cache_rd_arbiter;

    localparam int N = 3;

    logic              clk;
    logic              rst;
    logic [N-1:0]      c_rd_req, c_rd_gnt, c_rd_valid, c_rd_ready, c_rd_done;
    logic [N*16-1:0]   c_rd_len;
    logic [N*32-1:0]   c_rd_addr;
    logic [31:0]       c_rd_data, rd_data;
    logic              rd_req, rd_gnt, rd_ready, rd_valid, rd_done, len_err;
    logic [15:0]       rd_len;
    logic [31:0]       rd_addr;

    cache_rd_arbiter #(
        .NUM_CLIENTS(N),
        .addr_width (32),
        .data_width (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .c_rd_req  (c_rd_req),
        .c_rd_gnt  (c_rd_gnt),
        .c_rd_len  (c_rd_len),
        .c_rd_addr (c_rd_addr),
        .c_rd_data (c_rd_data),
        .c_rd_valid(c_rd_valid),
        .c_rd_ready(c_rd_ready),
        .c_rd_done (c_rd_done),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_len    (rd_len),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_done   (rd_done),
        .len_err   (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    int          len_a [N];
    logic [31:0] addr_a[N];
    int          ptr_m;
    int          last_beats;
    int          gnt_log[$];
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Per-cycle expectations
    logic [N-1:0] e_gnt, e_valid, e_done;
    logic         e_rd_req, e_rd_ready, e_len_err;
    logic [15:0]  e_rd_len;
    logic [31:0]  e_rd_addr, e_data;
    bit           e_data_chk;
    bit           cmp_en;

    int n_chk, n_pass;
    int done_cnt, lerr_cnt, beat_cnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Compare the DUT against the expectations of the current cycle, away from the clock edge.
    always @(negedge clk) begin
        #2;
        if (cmp_en) begin
            chk("c_rd_gnt",   64'(c_rd_gnt),   64'(e_gnt));
            chk("rd_req",     64'(rd_req),     64'(e_rd_req));
            chk("rd_ready",   64'(rd_ready),   64'(e_rd_ready));
            chk("c_rd_valid", 64'(c_rd_valid), 64'(e_valid));
            chk("c_rd_done",  64'(c_rd_done),  64'(e_done));
            chk("len_err",    64'(len_err),    64'(e_len_err));
            chk("rd_len",     64'(rd_len),     64'(e_rd_len));
            chk("rd_addr",    64'(rd_addr),    64'(e_rd_addr));
            if (e_data_chk) chk("c_rd_data", 64'(c_rd_data), 64'(e_data));
            for (int i = 0; i < N; i++) if (c_rd_gnt[i]) gnt_log.push_back(i);
            if (c_rd_done != '0)     done_cnt++;
            if (len_err)             lerr_cnt++;
            if (rd_valid && rd_ready) beat_cnt++;
        end
    end

    function automatic int rr_next(input logic [N-1:0] m);
        for (int i = 1; i <= N; i++) if (m[(ptr_m + i) % N]) return (ptr_m + i) % N;
        return -1;
    endfunction

    task automatic set_quiet();
        e_gnt = '0; e_valid = '0; e_done = '0;
        e_rd_req = 1'b0; e_rd_ready = 1'b0; e_len_err = 1'b0; e_data_chk = 1'b0;
    endtask

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            c_rd_len[i*16 +: 16]  = 16'(len_a[i]);
            c_rd_addr[i*32 +: 32] = addr_a[i];
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            c_rd_req = '0; rd_gnt = 1'b0; rd_done = 1'b0;
            rd_valid = 1'($urandom % 2); c_rd_ready = N'($urandom); rd_data = $urandom;
            set_quiet();
        end
    endtask

    // One full burst: arbitration, memory request, beat transfer, completion (or reset abort).
    task automatic run_burst(input logic [N-1:0] mask, input int short_by, input bit same_done,
                             input int gdelay, input bit use_pat, input int abort_after,
                             output int w);
        int           beats, target, k;
        bit           hs, fin;
        logic [N-1:0] oh;
        @(negedge clk);
        pack_inputs();
        c_rd_req = mask; rd_gnt = 1'b0; rd_done = 1'b0;
        rd_valid = 1'($urandom % 2); c_rd_ready = N'($urandom); rd_data = $urandom;
        set_quiet();
        w     = rr_next(mask);
        oh    = N'(1) << w;
        ptr_m = w;
        for (k = 0; k <= gdelay; k++) begin
            @(negedge clk);
            c_rd_req = c_rd_req & ~oh;
            rd_gnt   = (k == gdelay);
            rd_valid = 1'($urandom % 2); c_rd_ready = N'($urandom);
            set_quiet();
            e_rd_len  = 16'(len_a[w]);
            e_rd_addr = addr_a[w];
            e_gnt     = (k == 0) ? oh : '0;
            e_rd_req  = 1'b1;
        end
        target = len_a[w] + 1 - short_by;
        beats = 0; k = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            rd_gnt     = 1'b0;
            c_rd_req   = N'($urandom);
            rd_valid   = (beats < target) ? (use_pat ? 1'b1 : 1'($urandom % 2)) : 1'b0;
            c_rd_ready = N'($urandom);
            if (use_pat) c_rd_ready[w] = pat[k % 4];
            rd_data = $urandom;
            hs = rd_valid && c_rd_ready[w];
            if (hs) beats++;
            rd_done = (beats == target) && (same_done || !hs);
            set_quiet();
            e_rd_ready = c_rd_ready[w];
            e_valid    = rd_valid ? oh : '0;
            e_data_chk = rd_valid;
            e_data     = rd_data;
            k++;
            fin = rd_done;
            if (abort_after >= 0 && hs && beats == abort_after) begin
                @(negedge clk);
                rst = 1'b1; rd_valid = 1'b0; rd_done = 1'b0; c_rd_req = '0;
                c_rd_ready = N'($urandom);
                set_quiet();
                e_rd_ready = c_rd_ready[w];
                @(negedge clk);
                rst = 1'b0; rd_valid = 1'($urandom % 2); c_rd_ready = N'($urandom);
                set_quiet();
                e_rd_len = '0; e_rd_addr = '0;
                ptr_m = N - 1;
                last_beats = beats;
                return;
            end
        end
        @(negedge clk);
        rd_done = 1'b0; rd_valid = 1'($urandom % 2); c_rd_req = '0; c_rd_ready = N'($urandom);
        set_quiet();
        e_done    = oh;
        e_len_err = (beats != len_a[w] + 1);
        last_beats = beats;
    endtask

    initial begin
        int           w, d0, d1, sb, wp;
        logic [N-1:0] m;
        int           exp_order[4] = '{0, 1, 0, 1};
        n_chk = 0; n_pass = 0; done_cnt = 0; lerr_cnt = 0; beat_cnt = 0;
        cmp_en = 1'b0; ptr_m = N - 1;
        rst = 1'b1; c_rd_req = '0; c_rd_ready = '0; rd_gnt = 1'b0; rd_valid = 1'b0;
        rd_done = 1'b0; rd_data = '0; c_rd_len = '0; c_rd_addr = '0;
        for (int i = 0; i < N; i++) begin len_a[i] = 0; addr_a[i] = '0; end
        set_quiet(); e_rd_len = '0; e_rd_addr = '0; e_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        idle_cycles(2);

        // Single client, 4-beat burst at 0x100
        len_a[0] = 3; addr_a[0] = 32'h100; len_a[1] = 5; addr_a[1] = 32'h2000;
        d0 = done_cnt;
        run_burst(3'b001, 0, 1'b0, 2, 1'b0, -1, w);
        idle_cycles(1);
        chk("single_winner", 64'(w), 64'(0));
        chk("single_beats", 64'(last_beats), 64'(4));
        chk("single_addr", 64'(rd_addr), 64'(32'h100));
        chk("single_done_pulses", 64'(done_cnt - d0), 64'(1));

        // Short burst raises len_err once
        d1 = lerr_cnt;
        run_burst(3'b001, 1, 1'b0, 0, 1'b0, -1, w);
        idle_cycles(1);
        chk("lenerr_pulses", 64'(lerr_cnt - d1), 64'(1));

        // Final beat coincides with rd_done
        len_a[0] = 5; d1 = lerr_cnt;
        run_burst(3'b001, 0, 1'b1, 1, 1'b0, -1, w);
        idle_cycles(1);
        chk("samecyc_beats", 64'(last_beats), 64'(6));
        chk("samecyc_lenerr", 64'(lerr_cnt - d1), 64'(0));

        // Backpressure on client 1 over an 8-beat burst
        len_a[1] = 7; d0 = beat_cnt;
        run_burst(3'b010, 0, 1'b0, 1, 1'b1, -1, w);
        idle_cycles(1);
        chk("bp_winner", 64'(w), 64'(1));
        chk("bp_beats", 64'(beat_cnt - d0), 64'(8));

        // Reset after 2 of 4 beats: no done pulse
        len_a[0] = 3; d0 = done_cnt;
        run_burst(3'b001, 0, 1'b0, 0, 1'b0, 2, w);
        idle_cycles(1);
        chk("abort_done_pulses", 64'(done_cnt - d0), 64'(0));

        // Fairness from the reset pointer
        gnt_log.delete();
        for (int b = 0; b < 4; b++) begin
            len_a[0] = $urandom_range(0, 3); len_a[1] = $urandom_range(0, 3);
            run_burst(3'b011, 0, 1'($urandom % 2), $urandom_range(0, 2), 1'b0, -1, w);
        end
        idle_cycles(1);
        chk("fair_count", 64'(gnt_log.size()), 64'(4));
        for (int b = 0; b < 4 && b < gnt_log.size(); b++) chk("fair_order", 64'(gnt_log[b]), 64'(exp_order[b]));

        // Randomized bursts
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < N; i++) begin
                len_a[i]  = $urandom_range(0, 6);
                addr_a[i] = $urandom;
            end
            m  = N'($urandom_range(1, (1 << N) - 1));
            wp = rr_next(m);
            case ($urandom % 6)
                0:       sb = (len_a[wp] > 0) ? 1 : 0;
                1:       sb = -1;
                default: sb = 0;
            endcase
            run_burst(m, sb, 1'($urandom % 2), $urandom_range(0, 3), 1'b0, -1, w);
            if ($urandom % 4 == 0) idle_cycles($urandom_range(1, 3));
        end
        idle_cycles(2);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_rd_arbiter.md
CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 Parameter NUM_CLIENTS, default 2, number of cache-controller read requesters (2..8).
REQ-002 Parameter addr_width, default 32, address width.
REQ-003 Parameter data_width, default 32, data width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 c_rd_req  input  NUM_CLIENTS  per-client burst request, held until granted.
REQ-007 c_rd_gnt  output  NUM_CLIENTS  one-cycle grant pulse to the accepted client.
REQ-008 c_rd_len  input  NUM_CLIENTS x 16  per-client burst length in beats; 0 means 1 beat.
REQ-009 c_rd_addr  input  NUM_CLIENTS x addr_width  per-client burst start address.
REQ-010 c_rd_data  output  data_width  memory read data, broadcast to all clients.
REQ-011 c_rd_valid  output  NUM_CLIENTS  data valid, asserted only toward the owner.
REQ-012 c_rd_ready  input  NUM_CLIENTS  per-client data ready.
REQ-013 c_rd_done  output  NUM_CLIENTS  one-cycle burst-complete pulse to the owner.
REQ-014 rd_req / rd_gnt  output / input  1 / 1  memory-side burst request and grant.
REQ-015 rd_len / rd_addr  output  16 / addr_width  memory-side burst length and address, registered.
REQ-016 rd_data / rd_valid / rd_ready  input / input / output  data_width / 1 / 1  memory-side beat channel.
REQ-017 rd_done  input  1  memory-side burst-complete pulse.
REQ-018 len_err  output  1  one-cycle pulse: beat count at rd_done differed from rd_len+1.

Function
REQ-019 FSM states: IDLE, REQ, XFER, DONE; encoding is free.
REQ-020 IDLE: if any c_rd_req is set, pick a winner round-robin, starting at the index after the last winner, latch its len/addr into rd_len/rd_addr, pulse c_rd_gnt[winner], and go to REQ next cycle.
REQ-021 Round-robin pointer reset value is NUM_CLIENTS-1, so client 0 wins first; the pointer updates only on grant.
REQ-022 Grant latency: request seen in IDLE at cycle t gives c_rd_gnt at t+1 and rd_req at t+1.
REQ-023 REQ: rd_req held high; on rd_gnt, drop rd_req next cycle, clear the beat counter, and go to XFER.
REQ-024 XFER: rd_ready = c_rd_ready[owner]; c_rd_valid[owner] = rd_valid, combinational pass-through; other c_rd_valid bits are 0.
REQ-025 A beat counts when rd_valid && rd_ready; the counter is 17 bits and saturates at its maximum.
REQ-026 XFER: on rd_done go to DONE; a beat handshake in the same cycle as rd_done still counts.
REQ-027 DONE: pulse c_rd_done[owner] for one cycle; pulse len_err if count != rd_len+1; return to IDLE.
REQ-028 No re-arbitration mid-burst; a new c_rd_req arriving during XFER waits until IDLE.
REQ-029 A client that drops c_rd_req before grant is not granted; arbitration uses the current-cycle request.
REQ-030 rd_valid outside XFER is ignored; rd_ready is 0 outside XFER.
REQ-031 Throughput: back-to-back bursts have at least 2 idle cycles (DONE, IDLE) between rd_done and the next rd_req.

Reset
REQ-032 Under rst: state=IDLE; rd_req, rd_ready, all c_rd_gnt/c_rd_valid/c_rd_done, len_err=0; rd_len=0; rd_addr=0; counter=0; pointer=NUM_CLIENTS-1.
REQ-033 rst mid-burst aborts at once without c_rd_done; the memory side is reset by the same rst.

Structure
REQ-034 The shared package cache_pkg holds the FSM state typedef, LEN_W=16, and the round-robin helper function.
REQ-035 One sub-module, rr_arbiter (NUM_CLIENTS-wide, pointer-based, one-hot grant), is instantiated once.

Verification
REQ-036 Single client: c_rd_req[0], len=3, addr=0x100; memory gnt after 2 cycles, 4 beats, then done -> gnt[0] at t+1, rd_addr=0x100, 4 valid beats to client 0, c_rd_done[0] pulse, len_err=0.
REQ-037 Fairness: both clients request continuously for 4 bursts -> grant order 0,1,0,1.
REQ-038 Backpressure: c_rd_ready[1] toggles 1,0,0,1 during an 8-beat burst -> rd_ready mirrors it; exactly 8 beats are counted; no data is lost.
REQ-039 Length error: len=3, memory sends 3 beats then rd_done -> len_err pulses once in DONE.
REQ-040 rst asserted in XFER after 2 of 4 beats -> next cycle all outputs are 0 with no c_rd_done; the next request goes to client 0.
REQ-041 Simultaneous rd_valid&&rd_ready and rd_done on the final beat -> count includes the beat; len_err=0.
